majority_vote_stream: RTL

Parametrised, registered N-way bitwise majority voter for W-bit words, the next generation of the team's combinational 2-bit `majority` block. It accepts one N-channel sample per valid/ready handshake and emits the voted word one cycle later. It flags which channels disagreed and tracks persistent per-channel disagreement in saturating counters that raise sticky fault flags. It sits between redundant producers (replicated datapaths or sensors) and a single downstream consumer.

---
 rtl/majority_pkg.sv | 14 +
 rtl/majority_word.sv | 23 ++
 rtl/majority_vote_stream.sv | 57 +++++
 3 files changed

// File: rtl/majority_pkg.sv
// majority_pkg: shared defaults, width helper and parameter checks for the majority voter
package majority_pkg;
  localparam int N_DEF = 3;
  localparam int W_DEF = 2;
  localparam int FT_DEF = 4;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic bit params_ok(input int n, input int w, input int ft);
    return (n % 2 == 1) && n >= 3 && n <= 15 && w >= 1 && w <= 32 && ft >= 1 && ft <= 255;
  endfunction
endpackage

// File: rtl/majority_word.sv
// majority_word: combinational bitwise N-way majority vote with per-channel mismatch flags
module majority_word import majority_pkg::*; #(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic [N*W-1:0] data,
  output logic [W-1:0]   vote,
  output logic [N-1:0]   mismatch
);
  localparam int CW = clog2(N + 1);
  logic [CW-1:0] cnt;
  always_comb begin
    vote = '0;
    cnt = '0;
    mismatch = '0;
    for (int b = 0; b < W; b++) begin
      cnt = '0;
      for (int c = 0; c < N; c++) cnt = cnt + CW'(data[c*W+b]);
      vote[b] = cnt > CW'(N / 2);
    end
    for (int c = 0; c < N; c++) mismatch[c] = data[c*W +: W] != vote;
  end
endmodule

// File: rtl/majority_vote_stream.sv
// majority_vote_stream: registered N-way majority voter with handshake and sticky per-channel fault tracking
module majority_vote_stream import majority_pkg::*; #(
  parameter int N = N_DEF,
  parameter int W = W_DEF,
  parameter int FAULT_THRESH = FT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [N-1:0]   out_mismatch,
  output logic           out_unanimous,
  input  logic           fault_clr,
  output logic [N-1:0]   fault
);
  localparam int CW = clog2(FAULT_THRESH + 1);
  if (!params_ok(N, W, FAULT_THRESH)) begin : g_bad
    $error("majority_vote_stream: illegal parameters");
  end
  logic [W-1:0] vote;
  logic [N-1:0] mm;
  logic acc;
  logic [CW-1:0] cnt [N];
  majority_word #(.N(N), .W(W)) u_word (.data(in_data), .vote(vote), .mismatch(mm));
  assign in_ready = !rst && (!out_valid || out_ready);
  assign acc = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_mismatch <= '0;
      out_unanimous <= 1'b0;
      fault <= '0;
      for (int c = 0; c < N; c++) cnt[c] <= '0;
    end else begin
      if (acc) begin
        out_valid <= 1'b1;
        out_data <= vote;
        out_mismatch <= mm;
        out_unanimous <= ~|mm;
      end else if (out_ready) out_valid <= 1'b0;
      if (fault_clr) begin
        fault <= '0;
        for (int c = 0; c < N; c++) cnt[c] <= '0;
      end else if (acc) begin
        for (int c = 0; c < N; c++) begin
          cnt[c] <= !mm[c] ? '0 : cnt[c] == CW'(FAULT_THRESH) ? cnt[c] : cnt[c] + 1'b1;
          if (mm[c] && cnt[c] >= CW'(FAULT_THRESH - 1)) fault[c] <= 1'b1;
        end
      end
    end
  end
endmodule
